// File: rtl/bubble_pkg.sv
// bubble_pkg: region defaults, read-state enum and address width shared with the SPI loader
package bubble_pkg;
    localparam int ADDR_W    = 15;
    localparam int PAIR_W    = 11;
    localparam int BOOT_BASE = 4106;
    localparam int BOOT_LEN  = 3856;
    localparam int PAGE_BASE = 14336;
    localparam int PAGE_LEN  = 1168;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, READY} rd_state_t;

    // Index of the final pair of a region of len bits
    function automatic logic [PAIR_W-1:0] last_pair(input int len);
        return PAIR_W'(len / 2 - 1);
    endfunction
endpackage

// File: rtl/bubble_bit_ram.sv
// bubble_bit_ram: 1-bit wide simple dual-port RAM, registered read-first output
module bubble_bit_ram
    import bubble_pkg::*;
(
    input  logic              MCLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);
    logic mem [0:(1<<ADDR_W)-1];

    // Write and enabled read share the edge, so a colliding read returns the old bit
    always_ff @(posedge MCLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/bubble_out_buffer.sv
// bubble_out_buffer: loader-written bit buffer replayed to the bubble interface as bit pairs
module bubble_out_buffer
    import bubble_pkg::*;
(
    input  logic              MCLK,
    input  logic              RST,
    input  logic              nOUTBUFWCLKEN,
    input  logic [ADDR_W-1:0] OUTBUFWADDR,
    input  logic              OUTBUFWDATA,
    input  logic              RDSTART,
    input  logic              RDMODE,
    input  logic              BOUTTICK,
    output logic              DOUT0,
    output logic              DOUT1,
    output logic              DSTROBE,
    output logic              BUSY,
    output logic              DONE,
    output logic              UNDERRUN
);
    rd_state_t         state;
    logic [ADDR_W-1:0] base;
    logic [PAIR_W-1:0] last;
    logic [PAIR_W-1:0] pair;
    logic              even_q;
    logic              rd_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // Reads only in the fetch states, so rd_data keeps the staged odd bit while READY
    assign rd_en   = (state == FETCH0) || (state == FETCH1);
    assign rd_addr = base + {3'd0, pair, 1'b0} + {14'd0, state == FETCH1};

    bubble_bit_ram u_ram (
        .MCLK  (MCLK),
        .we    (!nOUTBUFWCLKEN),
        .waddr (OUTBUFWADDR),
        .wdata (OUTBUFWDATA),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Prefetch FSM: stage one pair ahead of the tick, emit on tick, flag early ticks
    always_ff @(posedge MCLK) begin
        if (RST) begin
            state    <= IDLE;
            base     <= '0;
            last     <= '0;
            pair     <= '0;
            even_q   <= 1'b0;
            DOUT0    <= 1'b1;
            DOUT1    <= 1'b1;
            DSTROBE  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            DSTROBE <= 1'b0;
            DONE    <= 1'b0;
            if (RDSTART) begin
                base     <= RDMODE ? ADDR_W'(PAGE_BASE) : ADDR_W'(BOOT_BASE);
                last     <= RDMODE ? last_pair(PAGE_LEN) : last_pair(BOOT_LEN);
                pair     <= '0;
                UNDERRUN <= 1'b0;
                BUSY     <= 1'b1;
                state    <= FETCH0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    FETCH0: state <= FETCH1;
                    FETCH1: begin
                        even_q <= rd_data;
                        state  <= READY;
                    end
                    READY: if (BOUTTICK) begin
                        DOUT0   <= even_q;
                        DOUT1   <= rd_data;
                        DSTROBE <= 1'b1;
                        pair    <= pair + 1'b1;
                        BUSY    <= pair != last;
                        DONE    <= pair == last;
                        state   <= pair == last ? IDLE : FETCH0;
                    end
                endcase
                if (BOUTTICK && rd_en) begin
                    UNDERRUN <= 1'b1;
                    DOUT0    <= 1'b1;
                    DOUT1    <= 1'b1;
                    DSTROBE  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bubble_out_buffer.sv
// tb_bubble_out_buffer: directed vector table plus multi-cycle playback sequences
module tb_bubble_out_buffer;
    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        nOUTBUFWCLKEN = 1'b1;
    logic [14:0] OUTBUFWADDR = '0;
    logic        OUTBUFWDATA = 1'b0;
    logic        RDSTART = 1'b0;
    logic        RDMODE = 1'b0;
    logic        BOUTTICK = 1'b0;
    logic        DOUT0, DOUT1, DSTROBE, BUSY, DONE, UNDERRUN;
    int          errors = 0;
    int          checks = 0;

    always #5 MCLK = ~MCLK;

    bubble_out_buffer dut (
        .MCLK          (MCLK),
        .RST           (RST),
        .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
        .OUTBUFWADDR   (OUTBUFWADDR),
        .OUTBUFWDATA   (OUTBUFWDATA),
        .RDSTART       (RDSTART),
        .RDMODE        (RDMODE),
        .BOUTTICK      (BOUTTICK),
        .DOUT0         (DOUT0),
        .DOUT1         (DOUT1),
        .DSTROBE       (DSTROBE),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .UNDERRUN      (UNDERRUN)
    );

    typedef struct {
        string name;
        logic  rs, md, tk;
        logic  strobe, busy, done, und, d0, d1;
    } vec_t;

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic mode, input int a);
        return mode ? ~a[0] : a[0] ^ a[3];
    endfunction

    task automatic wr(input int a, input logic d);
        nOUTBUFWCLKEN = 1'b0;
        OUTBUFWADDR   = 15'(a);
        OUTBUFWDATA   = d;
        cyc();
        nOUTBUFWCLKEN = 1'b1;
    endtask

    task automatic start(input logic mode);
        RDSTART = 1'b1;
        RDMODE  = mode;
        cyc();
        RDSTART = 1'b0;
    endtask

    task automatic early_tick();
        BOUTTICK = 1'b1;
        cyc();
        BOUTTICK = 1'b0;
    endtask

    // n ticks, 8 cycles apart, checking each emitted pair against the model
    task automatic ticks(input logic mode, input int p0, input int n, output int bad, output int dn);
        int a;
        bad = 0;
        dn  = 0;
        for (int i = 0; i < n; i++) begin
            repeat (7) begin
                cyc();
                if (DSTROBE !== 1'b0) bad++;
                if (DONE === 1'b1) dn++;
            end
            BOUTTICK = 1'b1;
            cyc();
            BOUTTICK = 0;
            if (DONE === 1'b1) dn++;
            a = (mode ? 14336 : 4106) + 2 * (p0 + i);
            if (DSTROBE !== 1'b1 || DOUT0 !== bit_of(mode, a) || DOUT1 !== bit_of(mode, a + 1)) begin
                if (bad == 0) $display("pair %0d: strobe=%b dout=%b%b", p0 + i, DSTROBE, DOUT0, DOUT1);
                bad++;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        vec_t tbl[13];
        int   bad, dn;
        tbl[0]  = '{"idle_tick",     0, 0, 1, 0, 0, 0, 0, 1, 1};
        tbl[1]  = '{"start_page",    1, 1, 0, 0, 1, 0, 0, 1, 1};
        tbl[2]  = '{"early_tick",    0, 0, 1, 1, 1, 0, 1, 1, 1};
        tbl[3]  = '{"fetch1",        0, 0, 0, 0, 1, 0, 1, 1, 1};
        tbl[4]  = '{"page_pair0",    0, 0, 1, 1, 1, 0, 1, 1, 0};
        tbl[5]  = '{"wait_a",        0, 0, 0, 0, 1, 0, 1, 1, 0};
        tbl[6]  = '{"wait_b",        0, 0, 0, 0, 1, 0, 1, 1, 0};
        tbl[7]  = '{"page_pair1",    0, 0, 1, 1, 1, 0, 1, 1, 0};
        tbl[8]  = '{"restart_tick",  1, 0, 1, 0, 1, 0, 0, 1, 0};
        tbl[9]  = '{"wait_c",        0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{"wait_d",        0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[11] = '{"boot_pair0",    0, 0, 1, 1, 1, 0, 0, 1, 0};
        tbl[12] = '{"fetch0_tick",   0, 0, 1, 1, 1, 0, 1, 1, 1};

        cyc();
        cyc();
        RST = 1'b0;
        chk("rst_dout", {DOUT0, DOUT1}, 2'b11);
        chk("rst_strobe", DSTROBE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_underrun", UNDERRUN, 0);

        for (int i = 0; i < 3856; i++) wr(4106 + i, bit_of(0, 4106 + i));
        for (int i = 0; i < 1168; i++) wr(14336 + i, bit_of(1, 14336 + i));

        for (int k = 0; k < 13; k++) begin
            RDSTART  = tbl[k].rs;
            RDMODE   = tbl[k].md;
            BOUTTICK = tbl[k].tk;
            cyc();
            RDSTART  = 1'b0;
            BOUTTICK = 1'b0;
            chk({tbl[k].name, "_strobe"}, DSTROBE, tbl[k].strobe);
            chk({tbl[k].name, "_busy"}, BUSY, tbl[k].busy);
            chk({tbl[k].name, "_done"}, DONE, tbl[k].done);
            chk({tbl[k].name, "_underrun"}, UNDERRUN, tbl[k].und);
            chk({tbl[k].name, "_dout"}, {DOUT0, DOUT1}, {tbl[k].d0, tbl[k].d1});
        end

        do_reset();
        start(0);
        chk("boot_busy_start", BUSY, 1);
        ticks(0, 0, 1928, bad, dn);
        chk("boot_pairs_bad", bad, 0);
        chk("boot_done_count", dn, 1);
        chk("boot_done_pulse", DONE, 1);
        chk("boot_busy_end", BUSY, 0);
        cyc();
        chk("boot_done_clear", DONE, 0);
        early_tick();
        chk("idle_tick_strobe", DSTROBE, 0);

        start(1);
        ticks(1, 0, 583, bad, dn);
        chk("page_pairs_bad", bad, 0);
        chk("page_busy_583", BUSY, 1);
        chk("page_done_early", dn, 0);
        ticks(1, 583, 1, bad, dn);
        chk("page_last_bad", bad, 0);
        chk("page_busy_end", BUSY, 0);
        chk("page_done", dn, 1);

        do_reset();
        start(0);
        early_tick();
        chk("rs_underrun_set", UNDERRUN, 1);
        ticks(0, 0, 100, bad, dn);
        chk("rs_first100_bad", bad, 0);
        repeat (7) cyc();
        RDSTART  = 1'b1;
        RDMODE   = 1'b1;
        BOUTTICK = 1'b1;
        cyc();
        RDSTART  = 1'b0;
        BOUTTICK = 1'b0;
        chk("rs_coinc_strobe", DSTROBE, 0);
        chk("rs_underrun_clr", UNDERRUN, 0);
        chk("rs_busy", BUSY, 1);
        ticks(1, 0, 1, bad, dn);
        chk("rs_page_pair0_bad", bad, 0);
        chk("rs_underrun_stays", UNDERRUN, 0);

        do_reset();
        start(0);
        early_tick();
        ticks(0, 0, 50, bad, dn);
        chk("mid_first50_bad", bad, 0);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_dout", {DOUT0, DOUT1}, 2'b11);
        chk("mid_rst_strobe", DSTROBE, 0);
        chk("mid_rst_underrun", UNDERRUN, 0);
        start(0);
        ticks(0, 0, 1, bad, dn);
        chk("mid_replay_bad", bad, 0);

        do_reset();
        start(1);
        wr(14336, 1'b0);
        repeat (6) cyc();
        early_tick();
        chk("coll_old_strobe", DSTROBE, 1);
        chk("coll_old_dout", {DOUT0, DOUT1}, 2'b10);
        start(1);
        repeat (7) cyc();
        early_tick();
        chk("coll_new_dout", {DOUT0, DOUT1}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
